ktr_binary_code: RTL and testbench
==================================

KTR_BINARY_CODE -- requirements
Module: ktr_binary_code

Interface
REQ-001 Parameter BIN_WIDTH, default 16: width of bin_o, bin_length_o, K and cMax.
REQ-002 Parameter VALUE_WIDTH, default 8: width of the symbol value N_i.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_i  input  1  start request; a rising level starts one binarization.
REQ-007 N_i  input  VALUE_WIDTH  symbol value to binarize.
REQ-008 K  input  BIN_WIDTH  Rice parameter (cRiceParam).
REQ-009 cMax  input  BIN_WIDTH  truncation maximum.
REQ-010 bin_o  output  BIN_WIDTH  bin string, LSB-justified; the first bin is at bit bin_length_o-1 and the last bin is at bit 0; unused upper bits are 0.
REQ-011 done_o  output  1  result valid; held high until the next accepted start.
REQ-012 bin_length_o  output  BIN_WIDTH  number of valid bins in bin_o.

Function
REQ-013 Start acceptance: start_i high while its registered previous value was low, in IDLE or DONE (edge detect, so a multi-cycle start_i is one request); start_i is ignored in PREFIX and SUFFIX.
REQ-014 On the accepting edge, register the operands: Kc = min(K, VALUE_WIDTH), cMax, and v = min(N_i, cMax); later input changes are ignored.
REQ-015 Derived values: pMax = cMax >> Kc; prefixVal = v >> Kc; suffixVal = v - (prefixVal << Kc).
REQ-016 Prefix: if prefixVal < pMax, emit prefixVal ones followed by one zero; otherwise emit pMax ones with no terminating zero.
REQ-017 Suffix: only when cMax > v and Kc > 0, emit suffixVal as Kc bits, MSB first.
REQ-018 Total length L = prefix bins + suffix bins.
REQ-019 States are IDLE, PREFIX, SUFFIX and DONE; the accepting edge goes to PREFIX (or to DONE if L = 0).
REQ-020 Each cycle in PREFIX or SUFFIX shifts exactly one bin into bin_o from the LSB (bin_o <= {bin_o, bin}) and increments bin_length_o.
REQ-021 PREFIX goes to SUFFIX after its last bin when a suffix exists, otherwise to DONE; SUFFIX goes to DONE after Kc bins.
REQ-022 Latency: done_o rises exactly max(L,1) rising edges after the accepting edge.
REQ-023 On the accepting edge, bin_o, bin_length_o and done_o clear to 0.
REQ-024 In DONE, bin_o and bin_length_o are held stable.
REQ-025 Overflow: when L > BIN_WIDTH, bins shift out of the MSB, and bin_length_o saturates at BIN_WIDTH.
REQ-026 N_i > cMax is clamped to cMax (see REQ-014), i.e. it produces the cMax codeword.

Reset
REQ-027 While rst_n is low, independent of clk: state = IDLE, bin_o = 0, bin_length_o = 0, done_o = 0, start edge register = 0.
REQ-028 Reset asserted mid-operation aborts the binarization; no done_o is produced for it.
REQ-029 After rst_n deasserts, a start_i already held high counts as a rising edge on the first clock.

Structure
REQ-030 Shared package ktr_pkg holds the state enum (IDLE, PREFIX, SUFFIX, DONE) and the default BIN_WIDTH/VALUE_WIDTH constants.
REQ-031 Single module, no sub-module: combinational derivation of pMax, prefixVal and suffixVal, plus an FSM with a shift register and a bin counter.

Verification
REQ-032 K=1, cMax=8, N=0 -> bin_o=0b00, bin_length_o=2, done_o after 2 cycles.
REQ-033 K=1, cMax=8, N=3 -> bin_o=0b101, length 3; N=5 -> 0b1101, length 4; N=7 -> 0b11101, length 5.
REQ-034 K=1, cMax=8, N=8..12 -> bin_o=0b1111, length 4 (clamped, no terminating zero, no suffix).
REQ-035 K=0, cMax=4: N=2 -> 0b110, length 3; N=4 -> 0b1111, length 4.
REQ-036 start_i held high for 3 cycles -> exactly one result; done_o stays high until the next rising edge of start_i, then clears.
REQ-037 rst_n pulsed low during PREFIX -> all outputs 0 immediately, no done_o; the next start works normally.

Source files
------------

// File: rtl/ktr_pkg.sv
// rtl/ktr_pkg.sv - shared state encoding and default widths for the Rice binarizer
package ktr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2,
    DONE   = 2'd3
  } ktr_state_e;

  localparam int KTR_BIN_WIDTH   = 16;
  localparam int KTR_VALUE_WIDTH = 8;

endpackage

// File: rtl/ktr_binary_code.sv
// rtl/ktr_binary_code.sv - truncated Rice binarizer, one bin per cycle into an LSB-first shift register
module ktr_binary_code
  import ktr_pkg::*;
#(
  parameter int BIN_WIDTH   = KTR_BIN_WIDTH,
  parameter int VALUE_WIDTH = KTR_VALUE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [VALUE_WIDTH-1:0] N_i,
  input  logic [BIN_WIDTH-1:0]   K,
  input  logic [BIN_WIDTH-1:0]   cMax,
  output logic [BIN_WIDTH-1:0]   bin_o,
  output logic                   done_o,
  output logic [BIN_WIDTH-1:0]   bin_length_o
);

  localparam logic [BIN_WIDTH-1:0] ONE = BIN_WIDTH'(1);
  localparam logic [BIN_WIDTH-1:0] VW  = BIN_WIDTH'(VALUE_WIDTH);
  localparam logic [BIN_WIDTH-1:0] BW  = BIN_WIDTH'(BIN_WIDTH);

  typedef struct packed {
    logic [BIN_WIDTH-1:0] prefix_val;
    logic [BIN_WIDTH-1:0] suffix_val;
    logic [BIN_WIDTH-1:0] prefix_len;
    logic                 has_suffix;
  } code_t;

  function automatic code_t derive(input logic [BIN_WIDTH-1:0] kc,
                                   input logic [BIN_WIDTH-1:0] cmax,
                                   input logic [BIN_WIDTH-1:0] v);
    code_t                c;
    logic [BIN_WIDTH-1:0] pmax;
    pmax         = cmax >> kc;
    c.prefix_val = v >> kc;
    c.suffix_val = v - (c.prefix_val << kc);
    // A clamped prefix has no terminating zero, so it is pMax bins long.
    c.prefix_len = (c.prefix_val < pmax) ? c.prefix_val + ONE : pmax;
    c.has_suffix = (cmax > v) && (kc != '0);
    return c;
  endfunction

  ktr_state_e           state, state_d;
  logic                 start_q;
  logic                 accept;
  logic [BIN_WIDTH-1:0] kc_in, n_ext, v_in;
  logic [BIN_WIDTH-1:0] kc_r, cnt;
  code_t                code_in, code_r;
  ktr_state_e           entry_state;
  logic                 shift_en, bin_bit;

  assign n_ext       = BIN_WIDTH'(N_i);
  assign kc_in       = (K > VW) ? VW : K;
  assign v_in        = (n_ext > cMax) ? cMax : n_ext;
  assign code_in     = derive(kc_in, cMax, v_in);
  assign accept      = start_i && !start_q && (state == IDLE || state == DONE);
  assign entry_state = (code_in.prefix_len != '0) ? PREFIX :
                       code_in.has_suffix          ? SUFFIX : DONE;

  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    bin_bit  = 1'b0;
    case (state)
      IDLE: if (accept) state_d = entry_state;
      PREFIX: begin
        shift_en = 1'b1;
        bin_bit  = (cnt < code_r.prefix_val);
        if (cnt == code_r.prefix_len - ONE)
          state_d = code_r.has_suffix ? SUFFIX : DONE;
      end
      SUFFIX: begin
        shift_en = 1'b1;
        bin_bit  = |(code_r.suffix_val & (ONE << (kc_r - ONE - cnt)));
        if (cnt == kc_r - ONE) state_d = DONE;
      end
      DONE: if (accept) state_d = entry_state;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q      <= 1'b0;
      kc_r         <= '0;
      code_r       <= '0;
      cnt          <= '0;
      bin_o        <= '0;
      bin_length_o <= '0;
      done_o       <= 1'b0;
    end else begin
      start_q <= start_i;
      if (accept) begin
        kc_r         <= kc_in;
        code_r       <= code_in;
        cnt          <= '0;
        bin_o        <= '0;
        bin_length_o <= '0;
        done_o       <= 1'b0;
      end else begin
        if (shift_en) begin
          bin_o <= {bin_o[BIN_WIDTH-2:0], bin_bit};
          if (bin_length_o != BW) bin_length_o <= bin_length_o + ONE;
          cnt <= (state_d != state) ? '0 : cnt + ONE;
        end
        // Zero-length codes sit in DONE one cycle before done_o rises.
        if (state_d == DONE || state == DONE) done_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ktr_binary_code.sv
// tb/tb_ktr_binary_code.sv - directed self-checking bench for ktr_binary_code
module tb_ktr_binary_code;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  N_i;
  logic [15:0] K, cMax;
  logic [15:0] bin_o, bin_length_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  localparam int NV = 16;
  int vk[NV] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 3, 20, 0, 0, 0};
  int vc[NV] = '{8, 8, 8, 8, 8, 8, 8, 8, 8, 4, 4, 5, 300, 0, 20, 20};
  int vn[NV] = '{0, 3, 5, 7, 8, 9, 10, 11, 12, 2, 4, 2, 5, 7, 20, 18};
  int vb[NV] = '{'h0, 'h5, 'hd, 'h1d, 'hf, 'hf, 'hf, 'hf, 'hf, 'h6, 'hf, 'h2, 'h5, 'h0, 'hffff, 'hfffe};
  int vl[NV] = '{2, 3, 4, 5, 4, 4, 4, 4, 4, 3, 4, 3, 9, 0, 16, 16};
  int vt[NV] = '{2, 3, 4, 5, 4, 4, 4, 4, 4, 3, 4, 3, 9, 1, 20, 19};

  always #5 clk = ~clk;

  ktr_binary_code #(.BIN_WIDTH(16), .VALUE_WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .N_i          (N_i),
    .K            (K),
    .cMax         (cMax),
    .bin_o        (bin_o),
    .done_o       (done_o),
    .bin_length_o (bin_length_o)
  );

  task automatic run_code(input int k, input int c, input int n, output int lat);
    @(negedge clk);
    K = 16'(k); cMax = 16'(c); N_i = 8'(n); start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; N_i = '0; K = '0; cMax = '0;
    #1;
    checks++;
    if (bin_o !== 16'h0 || bin_length_o !== 16'h0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: bin=%h len=%0d done=%b, required 0/0/0", bin_o, bin_length_o, done_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_done: done=%b, required 0", done_o);
    end
  endtask

  task automatic test_codes;
    int lat;
    for (int i = 0; i < NV; i++) begin
      run_code(vk[i], vc[i], vn[i], lat);
      checks++;
      if (lat !== vt[i]) begin
        errors++;
        $display("FAIL latency[%0d]: got %0d, required %0d", i, lat, vt[i]);
      end
      checks++;
      if (bin_o !== 16'(vb[i])) begin
        errors++;
        $display("FAIL bin[%0d]: got %h, required %h", i, bin_o, 16'(vb[i]));
      end
      checks++;
      if (bin_length_o !== 16'(vl[i])) begin
        errors++;
        $display("FAIL length[%0d]: got %0d, required %0d", i, bin_length_o, vl[i]);
      end
    end
  endtask

  task automatic test_start_held;
    int lat, rises;
    logic prev;
    @(negedge clk);
    K = 16'd1; cMax = 16'd8; N_i = 8'd3; start_i = 1'b1;
    lat = 0; rises = 0; prev = done_o;
    repeat (3) begin
      @(posedge clk);
      #1 lat++;
      if (done_o && !prev) rises++;
      prev = done_o;
    end
    start_i = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (done_o && !prev) rises++;
      prev = done_o;
    end
    checks++;
    if (rises !== 1) begin
      errors++;
      $display("FAIL held_start_results: got %0d done rises, required 1", rises);
    end
    checks++;
    if (done_o !== 1'b1 || bin_o !== 16'h5 || bin_length_o !== 16'd3) begin
      errors++;
      $display("FAIL held_start_result: done=%b bin=%h len=%0d, required 1/0005/3", done_o, bin_o, bin_length_o);
    end
    @(negedge clk) start_i = 1'b1;
    @(posedge clk);
    #1 checks++;
    if (done_o !== 1'b0 || bin_length_o !== 16'd0) begin
      errors++;
      $display("FAIL restart_clear: done=%b len=%0d, required 0/0", done_o, bin_length_o);
    end
    start_i = 1'b0;
    lat = 0;
    while (!done_o && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 3 || bin_o !== 16'h5) begin
      errors++;
      $display("FAIL restart_result: lat=%0d bin=%h, required 3/0005", lat, bin_o);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge clk);
    K = 16'd0; cMax = 16'd20; N_i = 8'd18; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; lat = 0;
    repeat (3) begin @(posedge clk); #1 lat++; end
    K = 16'd1; cMax = 16'd8; N_i = 8'd0; start_i = 1'b1;
    repeat (2) begin @(posedge clk); #1 lat++; end
    start_i = 1'b0;
    while (!done_o && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 19 || bin_o !== 16'hfffe || bin_length_o !== 16'd16) begin
      errors++;
      $display("FAIL busy_start_ignored: lat=%0d bin=%h len=%0d, required 19/fffe/16", lat, bin_o, bin_length_o);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    K = 16'd0; cMax = 16'd20; N_i = 8'd20; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checks++;
    if (bin_o !== 16'h0 || bin_length_o !== 16'h0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: bin=%h len=%0d done=%b, required 0/0/0", bin_o, bin_length_o, done_o);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    lat = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (done_o) lat++;
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("FAIL aborted_no_done: done seen %0d cycles, required 0", lat);
    end
    @(negedge clk);
    rst_n = 1'b0; K = 16'd1; cMax = 16'd8; N_i = 8'd7; start_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0; lat = 0;
    while (!done_o && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    checks++;
    if (lat !== 5 || bin_o !== 16'h1d || bin_length_o !== 16'd5) begin
      errors++;
      $display("FAIL start_after_reset: lat=%0d bin=%h len=%0d, required 5/001d/5", lat, bin_o, bin_length_o);
    end
  endtask

  initial begin
    test_reset();
    test_codes();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
